axi_mem_to_stream_tx: RTL
=========================

Name: axi_mem_to_stream_tx

Overview:
Read-side counterpart of the input AXI-stream path. It fetches a filtered frame from the AXI memory slave over one AXI4 read channel and transmits it as an AXI4-Stream video master, in raster order. It drives tuser on the first pixel of each frame and tlast on the last pixel of each line, which is the format the input stream path consumes. It sits between the AXI memory slave read port and the downstream sink (TB file writer or a next frame stage).

Parameters:
DATA_WIDTH, 32, pixel word width ({8'b0,R,G,B})
ADDR_WIDTH, 32, read address width; one address per pixel word
BURST_LEN, 16, maximum beats per AR burst (1..256)
FIFO_DEPTH, 32, data FIFO depth; power of 2, >= BURST_LEN

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a frame transfer when idle
base_addr  in  ADDR_WIDTH  word address of frame pixel 0; sampled on start
frame_width  in  16  pixels per line; sampled on start
frame_height  in  16  lines per frame; sampled on start
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse after the last stream beat is accepted
err  out  1  sticky rlast mismatch flag; cleared by the next accepted start
araddr  out  ADDR_WIDTH  burst start address
arlen  out  8  beats-1
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  DATA_WIDTH  read data
rlast  in  1  last beat of burst
rvalid  in  1  R valid
rready  out  1  R ready
m_axis_tdata  out  DATA_WIDTH  pixel
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last pixel of line
m_axis_tuser  out  1  first pixel of frame

Behaviour:
- Reset (rst=1, async): all outputs 0. FSM goes to IDLE, FIFO is emptied, counters are cleared. Reset mid-frame aborts with no done pulse.
- FSM states: IDLE, ADDR, DATA, DRAIN.
  - IDLE: on start, latch the inputs, clear err, set busy.
    - If width or height is 0, pulse done in the next cycle and return to IDLE.
    - Otherwise go to ADDR.
  - ADDR: assert arvalid only when FIFO free slots >= BURST_LEN. Hold araddr/arlen stable until arready. On the handshake go to DATA.
  - DATA: rready = 1 (credit guarantees space). Each rvalid beat is pushed to the FIFO. After arlen+1 beats, exit:
    - to ADDR if pixels remain to request;
    - else to DRAIN.
  - DRAIN: wait until the final stream beat is accepted, then pulse done and go to IDLE.
- Burst sizing: len = min(BURST_LEN, pixels remaining in the current line). Bursts never cross a line boundary.
  - araddr = base_addr + pixels already requested.
  - Exactly one burst is outstanding at a time.
- rlast check: if rlast differs from (beat == arlen) on any beat, set err. The beat count, not rlast, ends the burst.
- Stream side:
  - tvalid = FIFO not empty; tdata = FIFO head.
  - Output column and row counters advance on tvalid&tready.
  - tuser = (row==0 && col==0); tlast = (col==frame_width-1).
  - tdata, tlast and tuser are stable while tvalid=1 and tready=0.
- Latency:
  - start to first arvalid: 1 cycle (if the FIFO is empty).
  - R beat push to tvalid: 1 cycle.
- start while busy: ignored.
- Simultaneous FIFO push and pop: allowed, count unchanged; a full FIFO with a pop still accepts the push.
- Arithmetic: the total pixel count is a 32-bit product; the address adds modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package: FSM state enum, the 32-bit pixel count type, and the pixel packing constant (8'b0,R,G,B byte positions).
- Sub-module sync_fifo (DATA_WIDTH x FIFO_DEPTH): outputs count, full and empty; registered dout.
- Stream flag and counter logic stays in the top of the block.

Test Plan:
1. width=4, height=2, base=0x10, BURST_LEN=16, tready=1: exactly two bursts, (araddr 0x10, arlen 3) then (0x14, 3). Stream data mem[0x10..0x17]; tuser on beat 0 only; tlast on beats 3 and 7; done pulses one cycle after beat 7.
2. width=40, height=1, BURST_LEN=16: bursts have arlen 15, 15, 7 at addresses base, +16, +32. Output is 40 beats with tlast on beat 39.
3. Backpressure: tready toggles 1 cycle on, 3 cycles off. No arvalid is issued while FIFO free space < 16. Outputs are held stable while stalled. All 1280x720 pixels arrive in order; done pulses once.
4. Memory returns rlast on beat 2 of a 4-beat burst: err=1, the transfer still completes, and err clears on the next start.
5. width=0: done pulses one cycle after start; arvalid never asserts. A start pulse mid-frame is ignored and busy stays high.
6. rst asserted mid-DATA: arvalid, rready, tvalid and busy drop immediately, with no done. A new start then runs cleanly from the new base_addr.

Source files
------------

// File: rtl/axi_mem_to_stream_tx_pkg.sv
// Shared types for the memory-to-stream transmit path: FSM states, pixel
// count type, pixel byte layout and the burst sizing helper.
package axi_mem_to_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } state_t;

    typedef logic [31:0] pix_cnt_t;

    // Pixel word is {8'b0, R, G, B}
    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 0;

    function automatic pix_cnt_t burst_pixels(input pix_cnt_t line_rem, input int unsigned max_len);
        return (line_rem < max_len) ? line_rem : pix_cnt_t'(max_len);
    endfunction

endpackage

// File: rtl/axi_mem_to_stream_tx_sync_fifo.sv
// Synchronous show-ahead FIFO with a registered head word; a push into an
// empty FIFO appears on dout the following cycle.
module axi_mem_to_stream_tx_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [AW:0]           r_count, w_count_next;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_push, w_pop;

    assign full         = (r_count == (AW+1)'(DEPTH));
    assign empty        = (r_count == '0);
    assign w_pop        = pop && !empty;
    assign w_push       = push && (!full || w_pop);
    assign w_rd_next    = r_rd_ptr + AW'(w_pop);
    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign dout         = r_dout;
    assign count        = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            // Next head is either already stored or is the word being written now
            if (w_count_next != '0)
                r_dout <= (w_push && (r_wr_ptr == w_rd_next)) ? din : r_mem[w_rd_next];
        end
    end

endmodule

// File: rtl/axi_mem_to_stream_tx.sv
// Fetches a frame over AXI4 read bursts (line-bounded, one outstanding) and
// replays it as an AXI4-Stream video master with tuser/tlast framing.
module axi_mem_to_stream_tx
    import axi_mem_to_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-1:0] r_base, r_araddr;
    logic [15:0]           r_width, r_height, r_col, r_row;
    pix_cnt_t              r_total, r_req, r_line_rem;
    logic [7:0]            r_arlen, r_cur_len, r_beat;
    logic                  r_busy, r_done, r_err;

    logic                  w_start_acc, w_zero, w_free_ok, w_ar_hs, w_r_hs;
    logic                  w_burst_end, w_pop, w_last_pix;
    pix_cnt_t              w_len, w_req_next, w_rem_after, w_rem_next;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_full, w_fifo_empty;

    assign w_start_acc = start && (r_state == ST_IDLE) && !r_busy;
    assign w_zero      = (frame_width == 16'd0) || (frame_height == 16'd0);
    assign w_free_ok   = (pix_cnt_t'(FIFO_DEPTH) - pix_cnt_t'(w_fifo_count)) >= pix_cnt_t'(BURST_LEN);
    assign w_ar_hs     = arvalid && arready;
    assign w_r_hs      = rvalid && rready;
    assign w_burst_end = w_r_hs && (r_beat == r_cur_len);
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    assign w_last_pix  = (r_row == r_height - 16'd1) && (r_col == r_width - 16'd1);

    assign w_len       = pix_cnt_t'(r_arlen) + pix_cnt_t'(1);
    assign w_req_next  = r_req + w_len;
    assign w_rem_after = r_line_rem - w_len;
    assign w_rem_next  = (w_rem_after == '0) ? pix_cnt_t'(r_width) : w_rem_after;

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign araddr        = r_araddr;
    assign arlen         = r_arlen;
    assign m_axis_tdata  = w_fifo_dout;
    assign m_axis_tvalid = !w_fifo_empty;
    assign m_axis_tuser  = m_axis_tvalid && (r_row == 16'd0) && (r_col == 16'd0);
    assign m_axis_tlast  = m_axis_tvalid && (r_col == r_width - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start_acc && !w_zero) w_next_state = ST_ADDR;
            ST_ADDR: begin
                // Only request when the whole burst is guaranteed to fit
                arvalid = w_free_ok;
                if (w_free_ok && arready) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                rready = 1'b1;
                if (w_burst_end) w_next_state = (r_req < r_total) ? ST_ADDR : ST_DRAIN;
            end
            ST_DRAIN: if (w_pop && w_last_pix) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_base     <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_cur_len  <= '0;
            r_beat     <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_total    <= '0;
            r_req      <= '0;
            r_line_rem <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else begin
            r_done <= (w_start_acc && w_zero) || ((r_state == ST_DRAIN) && w_pop && w_last_pix);
            if (w_start_acc) begin
                r_busy     <= 1'b1;
                r_err      <= 1'b0;
                r_base     <= base_addr;
                r_width    <= frame_width;
                r_height   <= frame_height;
                r_total    <= pix_cnt_t'(frame_width) * pix_cnt_t'(frame_height);
                r_req      <= '0;
                r_line_rem <= pix_cnt_t'(frame_width);
                r_araddr   <= base_addr;
                r_arlen    <= 8'(burst_pixels(pix_cnt_t'(frame_width), BURST_LEN) - pix_cnt_t'(1));
                r_beat     <= '0;
                r_col      <= '0;
                r_row      <= '0;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            // araddr/arlen move on to the next burst once this one is accepted
            if (w_ar_hs) begin
                r_cur_len  <= r_arlen;
                r_req      <= w_req_next;
                r_line_rem <= w_rem_next;
                r_araddr   <= r_base + ADDR_WIDTH'(w_req_next);
                r_arlen    <= 8'(burst_pixels(w_rem_next, BURST_LEN) - pix_cnt_t'(1));
            end
            if (w_r_hs) begin
                if (rlast != (r_beat == r_cur_len)) r_err <= 1'b1;
                r_beat <= w_burst_end ? 8'd0 : r_beat + 8'd1;
            end
            if (w_pop) begin
                if (r_col == r_width - 16'd1) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end
        end
    end

    axi_mem_to_stream_tx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_r_hs),
        .din   (rdata),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Read credit means a beat never arrives at a full FIFO unless a pop frees a slot
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_r_hs && w_fifo_full && !w_pop));

endmodule
